// File: rtl/axi_llc_way_arb.sv
// axi_llc_way_arb: per-way round-robin scheduler between the four LLC units and the data ways.
// Define AXI_LLC_WAY_ARB_STATS_EN for per-unit grant/stall statistics counters.
module axi_llc_way_arb #(
  parameter int unsigned NumWays     = 8,
  parameter int unsigned MaxRdOut    = 4,
  parameter int unsigned StarveLimit = 16,
  localparam int unsigned CntW       = $clog2(MaxRdOut + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [3:0]                    req_valid_i,
  input  logic [3:0][NumWays-1:0]       req_way_ind_i,
  output logic [3:0]                    req_ready_o,
  output logic [NumWays-1:0]            way_valid_o,
  output logic [NumWays-1:0][1:0]       way_unit_o,
  input  logic [NumWays-1:0]            way_ready_i,
  input  logic [3:0]                    rd_done_i,
  output logic [3:0][CntW-1:0]          rd_cnt_o,
  output logic                          err_o
`ifdef AXI_LLC_WAY_ARB_STATS_EN
  ,
  input  logic                          stat_clr_i,
  output logic [3:0][31:0]              stat_grant_o,
  output logic [3:0][31:0]              stat_stall_o
`endif
);

  localparam int unsigned SW = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] RD_MAX = CntW'(MaxRdOut);
  localparam logic [SW-1:0] ST_MAX = SW'(StarveLimit);
  // Evict (0) and RChan (3) consume read credits
  localparam logic [3:0] RD_UNIT = 4'b1001;

  logic [3:0][CntW-1:0]    rd_cnt_q;
  logic [3:0][SW-1:0]      starve_q;
  logic [NumWays-1:0]      lock_q;
  logic [NumWays-1:0][1:0] lock_unit_q;
  logic [NumWays-1:0][1:0] ptr_q;
  logic                    err_q;

  logic [3:0]              one_hot;
  logic [3:0]              elig;
  logic [3:0]              starved;
  logic [3:0]              hs;
  logic [NumWays-1:0][3:0] cand;
  logic [NumWays-1:0][1:0] gnt;
  logic [NumWays-1:0]      gnt_vld;

  always_comb begin
    for (int u = 0; u < 4; u++) begin
      one_hot[u] = $onehot(req_way_ind_i[u]);
      starved[u] = starve_q[u] == ST_MAX;
      elig[u]    = rst_ni & req_valid_i[u] & one_hot[u]
                 & ~(RD_UNIT[u] & (rd_cnt_q[u] == RD_MAX));
    end
  end

  always_comb begin
    cand        = '0;
    gnt         = '0;
    gnt_vld     = '0;
    req_ready_o = '0;
    way_unit_o  = '0;
    for (int j = 0; j < NumWays; j++) begin
      for (int u = 0; u < 4; u++) begin
        cand[j][u] = elig[u] & req_way_ind_i[u][j];
      end
      if (lock_q[j]) begin
        gnt[j]     = lock_unit_q[j];
        gnt_vld[j] = cand[j][lock_unit_q[j]];
      end else begin
        // descending scans: the last hit written is the preferred one
        for (int u = 3; u >= 0; u--) begin
          if (cand[j][u] && starved[u]) begin
            gnt[j]     = 2'(u);
            gnt_vld[j] = 1'b1;
          end
        end
        if (!gnt_vld[j]) begin
          for (int k = 3; k >= 0; k--) begin
            if (cand[j][ptr_q[j] + 2'(k)]) begin
              gnt[j]     = ptr_q[j] + 2'(k);
              gnt_vld[j] = 1'b1;
            end
          end
        end
      end
      if (gnt_vld[j]) begin
        way_unit_o[j] = gnt[j];
        if (way_ready_i[j]) req_ready_o[gnt[j]] = 1'b1;
      end
    end
  end

  assign way_valid_o = gnt_vld;
  assign hs          = req_ready_o;
  assign rd_cnt_o    = rd_cnt_q;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= '0;
      lock_unit_q <= '0;
      ptr_q       <= '0;
    end else begin
      for (int j = 0; j < NumWays; j++) begin
        unique case (1'b1)
          gnt_vld[j] & ~way_ready_i[j]: begin
            lock_q[j]      <= 1'b1;
            lock_unit_q[j] <= gnt[j];
          end
          gnt_vld[j] & way_ready_i[j]: begin
            lock_q[j] <= 1'b0;
            ptr_q[j]  <= gnt[j] + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (RD_UNIT[u]) begin
          rd_cnt_q[u] <= rd_cnt_q[u] + CntW'(hs[u])
                       - CntW'(rd_done_i[u] && rd_cnt_q[u] != '0);
        end
        if (!req_valid_i[u] || hs[u]) begin
          starve_q[u] <= '0;
        end else if (!starved[u]) begin
          starve_q[u] <= starve_q[u] + SW'(1);
        end
      end
      err_q <= err_q | (|(req_valid_i & ~one_hot));
    end
  end

`ifdef AXI_LLC_WAY_ARB_STATS_EN
  logic [3:0][31:0] grant_q;
  logic [3:0][31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
      stall_q <= '0;
    end else if (stat_clr_i) begin
      grant_q <= '0;
      stall_q <= '0;
    end else begin
      for (int u = 0; u < 4; u++) begin
        grant_q[u] <= grant_q[u] + 32'(hs[u]);
        if (req_valid_i[u] && !req_ready_o[u] && stall_q[u] != '1) begin
          stall_q[u] <= stall_q[u] + 32'd1;
        end
      end
    end
  end

  assign stat_grant_o = grant_q;
  assign stat_stall_o = stall_q;
`endif

`ifndef SYNTHESIS
  for (genvar j = 0; j < NumWays; j++) begin : g_lock_sva
    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      lock_q[j] |-> req_valid_i[lock_unit_q[j]]);
  end
  for (genvar u = 0; u < 4; u++) begin : g_done_sva
    if (u == 0 || u == 3) begin : g_rd
      a_done_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_done_i[u] && rd_cnt_q[u] == '0));
    end
  end
`endif

endmodule

// File: tb/tb_axi_llc_way_arb.sv
// tb_axi_llc_way_arb: random stimulus against a rule-level reference model.
// Covers reset, RR, lock-in, read credits, starvation and the sticky error flag.
module tb_axi_llc_way_arb;
  localparam int NW = 8;
  localparam int MR = 4;
  localparam int SL = 16;
  localparam int CW = $clog2(MR + 1);

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [3:0]           req_valid_i = '0;
  logic [3:0][NW-1:0]   req_way_ind_i = '0;
  logic [3:0]           req_ready_o;
  logic [NW-1:0]        way_valid_o;
  logic [NW-1:0][1:0]   way_unit_o;
  logic [NW-1:0]        way_ready_i = '0;
  logic [3:0]           rd_done_i = '0;
  logic [3:0][CW-1:0]   rd_cnt_o;
  logic                 err_o;
`ifdef AXI_LLC_WAY_ARB_STATS_EN
  logic                 stat_clr_i = 1'b0;
  logic [3:0][31:0]     stat_grant_o;
  logic [3:0][31:0]     stat_stall_o;
`endif

  always #5 clk = ~clk;

  axi_llc_way_arb #(
    .NumWays(NW), .MaxRdOut(MR), .StarveLimit(SL)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .req_valid_i(req_valid_i),
    .req_way_ind_i(req_way_ind_i),
    .req_ready_o(req_ready_o),
    .way_valid_o(way_valid_o),
    .way_unit_o(way_unit_o),
    .way_ready_i(way_ready_i),
    .rd_done_i(rd_done_i),
    .rd_cnt_o(rd_cnt_o),
    .err_o(err_o)
`ifdef AXI_LLC_WAY_ARB_STATS_EN
    ,
    .stat_clr_i(stat_clr_i),
    .stat_grant_o(stat_grant_o),
    .stat_stall_o(stat_stall_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  int m_lock[NW];
  int m_ptr[NW];
  int m_rd[4];
  int m_st[4];
  bit m_err;
  bit e_valid[NW];
  int e_unit[NW];
  bit e_ready[4];
  bit pend[4];
  logic [NW-1:0] pway[4];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_rd(input int u);
    return u == 0 || u == 3;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < NW; j++) begin
      m_lock[j] = -1;
      m_ptr[j]  = 0;
    end
    for (int u = 0; u < 4; u++) begin
      m_rd[u] = 0;
      m_st[u] = 0;
      pend[u] = 0;
    end
    m_err = 0;
  endfunction

  function automatic void model_eval();
    bit el[4];
    int g;
    int u2;
    for (int u = 0; u < 4; u++) begin
      el[u] = rst_ni && req_valid_i[u]
           && $countones(req_way_ind_i[u]) == 1
           && !(is_rd(u) && m_rd[u] == MR);
      e_ready[u] = 0;
    end
    for (int j = 0; j < NW; j++) begin
      g = -1;
      if (m_lock[j] >= 0) begin
        if (el[m_lock[j]] && req_way_ind_i[m_lock[j]][j]) g = m_lock[j];
      end else begin
        for (int u = 0; u < 4; u++)
          if (g < 0 && el[u] && req_way_ind_i[u][j] && m_st[u] == SL) g = u;
        for (int k = 0; k < 4; k++) begin
          u2 = (m_ptr[j] + k) % 4;
          if (g < 0 && el[u2] && req_way_ind_i[u2][j]) g = u2;
        end
      end
      e_valid[j] = g >= 0;
      e_unit[j]  = (g >= 0) ? g : 0;
      if (g >= 0 && way_ready_i[j]) e_ready[g] = 1;
    end
  endfunction

  function automatic void model_step();
    for (int j = 0; j < NW; j++) begin
      if (e_valid[j]) begin
        if (way_ready_i[j]) begin
          m_lock[j] = -1;
          m_ptr[j]  = (e_unit[j] + 1) % 4;
        end else begin
          m_lock[j] = e_unit[j];
        end
      end
    end
    for (int u = 0; u < 4; u++) begin
      if (is_rd(u))
        m_rd[u] += (e_ready[u] ? 1 : 0)
                 - ((rd_done_i[u] && m_rd[u] > 0) ? 1 : 0);
      if (!req_valid_i[u] || e_ready[u]) m_st[u] = 0;
      else if (m_st[u] < SL) m_st[u]++;
      if (req_valid_i[u] && $countones(req_way_ind_i[u]) != 1) m_err = 1;
      if (e_ready[u]) pend[u] = 0;
    end
  endfunction

  task automatic compare();
    logic [NW-1:0] ev;
    logic [3:0]    er;
    for (int j = 0; j < NW; j++) ev[j] = e_valid[j];
    for (int u = 0; u < 4; u++) er[u] = e_ready[u];
    chk("way_valid", way_valid_o, ev);
    chk("req_ready", req_ready_o, er);
    for (int j = 0; j < NW; j++)
      if (e_valid[j]) chk($sformatf("way_unit[%0d]", j), way_unit_o[j], e_unit[j]);
    for (int u = 0; u < 4; u++)
      chk($sformatf("rd_cnt[%0d]", u), rd_cnt_o[u], is_rd(u) ? m_rd[u] : 0);
    chk("err", err_o, m_err);
  endtask

  function automatic logic [NW-1:0] pick(input logic [NW-1:0] mask);
    int w;
    do w = $urandom_range(NW - 1); while (!mask[w]);
    return NW'(1) << w;
  endfunction

  task automatic cycle(input int p_req, input logic [NW-1:0] wmask,
                       input int p_rdy, input int p_done);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      if (!pend[u] && $urandom_range(99) < p_req) begin
        pend[u] = 1;
        pway[u] = pick(wmask);
      end
      req_valid_i[u]   = pend[u];
      req_way_ind_i[u] = pend[u] ? pway[u] : NW'($urandom);
      rd_done_i[u]     = (!is_rd(u) || m_rd[u] > 0)
                      && $urandom_range(99) < p_done;
    end
    for (int j = 0; j < NW; j++) way_ready_i[j] = $urandom_range(99) < p_rdy;
    #1;
    model_eval();
    compare();
    @(posedge clk);
    model_step();
  endtask

  task automatic reset_check();
    chk("rst_way_valid", way_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_way_unit", way_unit_o, 0);
    chk("rst_rd_cnt", rd_cnt_o, 0);
    chk("rst_err", err_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    model_reset();
    req_valid_i = 4'hF;
    for (int u = 0; u < 4; u++) req_way_ind_i[u] = NW'(1);
    way_ready_i = '1;
    rd_done_i   = '0;
    #1;
    reset_check();
    repeat (2) @(negedge clk);
    reset_check();
    req_valid_i = '0;
    rst_ni = 1'b1;
  endtask

  task automatic all_to_way0();
    for (int u = 0; u < 4; u++) begin
      pend[u] = 1;
      pway[u] = NW'(1);
    end
    cycle(0, '1, 100, 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    all_to_way0();
    repeat (400) cycle(60, '1, 70, 30);
    repeat (600) cycle(80, NW'(8'b0000_0011), 15, 20);
    repeat (400) cycle(90, '1, 90, 5);
    repeat (300) cycle(70, NW'(8'b0010_0100), 40, 25);
    do_reset();
    all_to_way0();
    repeat (300) cycle(60, '1, 60, 30);
    pend[2] = 1;
    pway[2] = NW'(8'b0000_0110);
    repeat (200) cycle(70, '1, 50, 30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
